bot_updt_handshake: RTL and testbench

BOT_UPDT_HANDSHAKE -- requirements
Module: bot_updt_handshake

---
 rtl/bot_updt_handshake.sv | 138 +++++++++++++
 tb/tb_bot_updt_handshake.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_updt_handshake.sv
// Per-channel CDC update capture with pending/acknowledge handshake, overrun counting
// and a registered lowest-index interrupt request.
module bot_updt_handshake #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int OVF_W       = 8,
  parameter int EDGE_MODE   = 1,
  localparam int ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  SI_Reset_N,
  input  logic [N_CH-1:0]       IO_BotUpdt,
  input  logic [N_CH-1:0]       IO_INT_ACK,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       ovf_clr,
  output logic [N_CH-1:0]       IO_BotUpdt_Sync,
  output logic                  int_req,
  output logic [ID_W-1:0]       int_id,
  output logic [N_CH*OVF_W-1:0] ovf_cnt
);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync_d [SYNC_STAGES];
  logic [N_CH-1:0]  hist_q;
  logic [N_CH-1:0]  hist_d;
  logic [SYNC_STAGES:0] vld_q;
  logic [SYNC_STAGES:0] vld_d;
  logic [N_CH-1:0]  pending_q;
  logic [N_CH-1:0]  pending_d;
  logic [OVF_W-1:0] cnt_q [N_CH];
  logic [OVF_W-1:0] cnt_d [N_CH];
  logic             int_req_q;
  logic             int_req_d;
  logic [ID_W-1:0]  int_id_q;
  logic [ID_W-1:0]  int_id_d;
  logic [N_CH-1:0]  sync_last_s;
  logic [N_CH-1:0]  event_s;
  logic [N_CH-1:0]  ev_en_s;

  // Plain synchronizer shift; vld tracks how many stages hold post-reset samples.
  always_comb begin
    sync_d[0] = IO_BotUpdt;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    sync_last_s = sync_q[SYNC_STAGES-1];
    hist_d      = sync_last_s;
    vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
  end

  // An edge only counts once the history flop holds a real post-reset sample,
  // so a source held high across reset release is not mistaken for a new edge.
  always_comb begin
    if (EDGE_MODE != 0) begin
      event_s = sync_last_s & ~hist_q & {N_CH{vld_q[SYNC_STAGES]}};
    end else begin
      event_s = sync_last_s;
    end
    ev_en_s = event_s & ch_en;
  end

  // Pending handshake and saturating overrun counters, per channel.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ovf_clr[i]) begin
        cnt_d[i] = {OVF_W{1'b0}};
      end else if (ev_en_s[i] && pending_q[i] && !IO_INT_ACK[i] &&
                   (cnt_q[i] != {OVF_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + OVF_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      if (ev_en_s[i]) begin
        pending_d[i] = 1'b1;
      end else if (IO_INT_ACK[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // Interrupt summary is built from the registered pending flags.
  always_comb begin
    int_req_d = |pending_q;
    int_id_d  = {ID_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        int_id_d = ID_W'(i);
      end else begin
        int_id_d = int_id_d;
      end
    end
  end

  // All state flops.
  always_ff @(posedge clk or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {N_CH{1'b0}};
      end
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= {OVF_W{1'b0}};
      end
      hist_q    <= {N_CH{1'b0}};
      vld_q     <= {(SYNC_STAGES+1){1'b0}};
      pending_q <= {N_CH{1'b0}};
      int_req_q <= 1'b0;
      int_id_q  <= {ID_W{1'b0}};
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      hist_q    <= hist_d;
      vld_q     <= vld_d;
      pending_q <= pending_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  // Output mapping straight from flops.
  always_comb begin
    ovf_cnt = {(N_CH*OVF_W){1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      ovf_cnt[i*OVF_W +: OVF_W] = cnt_q[i];
    end
    IO_BotUpdt_Sync = pending_q;
    int_req         = int_req_q;
    int_id          = int_id_q;
  end

endmodule

// File: tb/tb_bot_updt_handshake.sv
// Self-checking bench: edge-mode 16-channel instance and level-mode 4-channel instance
// compared every cycle against a sample-history reference model, plus directed literals.
module tb_bot_updt_handshake;

  logic clk;
  logic rst_n;
  logic [15:0]  a_upd, a_ack, a_en, a_clr, a_sync;
  logic         a_req;
  logic [3:0]   a_id;
  logic [127:0] a_ovf;
  logic [3:0]   b_upd, b_ack, b_en, b_clr, b_sync;
  logic         b_req;
  logic [1:0]   b_id;
  logic [31:0]  b_ovf;

  int checks;
  int failures;

  // reference model state, index 0 = instance A, 1 = instance B
  logic [15:0] m_pend [2];
  int          m_cnt  [2][16];
  logic        m_req  [2];
  int          m_id   [2];
  logic [15:0] m_smp  [2][5];
  int          m_ns   [2];

  bot_updt_handshake #(.N_CH(16), .SYNC_STAGES(3), .OVF_W(8), .EDGE_MODE(1)) dut_a (
    .clk(clk), .SI_Reset_N(rst_n), .IO_BotUpdt(a_upd), .IO_INT_ACK(a_ack),
    .ch_en(a_en), .ovf_clr(a_clr), .IO_BotUpdt_Sync(a_sync), .int_req(a_req),
    .int_id(a_id), .ovf_cnt(a_ovf));

  bot_updt_handshake #(.N_CH(4), .SYNC_STAGES(2), .OVF_W(8), .EDGE_MODE(0)) dut_b (
    .clk(clk), .SI_Reset_N(rst_n), .IO_BotUpdt(b_upd), .IO_INT_ACK(b_ack),
    .ch_en(b_en), .ovf_clr(b_clr), .IO_BotUpdt_Sync(b_sync), .int_req(b_req),
    .int_id(b_id), .ovf_cnt(b_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic mreset(input int k);
    m_pend[k] = 16'h0;
    m_req[k]  = 1'b0;
    m_id[k]   = 0;
    m_ns[k]   = 0;
    for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
    for (int j = 0; j < 5; j++) m_smp[k][j] = 16'h0;
  endtask

  // The synchronized value is the source as sampled S edges earlier; nothing from before reset counts.
  task automatic mstep(input int k, input int S, input bit em, input int n,
                       input logic [15:0] upd, input logic [15:0] ack,
                       input logic [15:0] en, input logic [15:0] clr);
    logic [15:0] sync, ev, msk;
    if (!rst_n) begin
      mreset(k);
      return;
    end
    msk  = (n == 16) ? 16'hFFFF : ((16'h1 << n) - 16'h1);
    sync = (m_ns[k] >= S) ? m_smp[k][S-1] : 16'h0;
    if (em) ev = (m_ns[k] >= S + 1) ? (sync & ~m_smp[k][S]) : 16'h0;
    else    ev = sync;
    ev = ev & en & msk;
    m_req[k] = |m_pend[k];
    m_id[k]  = 0;
    for (int i = n - 1; i >= 0; i--) if (m_pend[k][i]) m_id[k] = i;
    for (int i = 0; i < n; i++) begin
      if (clr[i]) m_cnt[k][i] = 0;
      else if (ev[i] && m_pend[k][i] && !ack[i] && m_cnt[k][i] < 255) m_cnt[k][i]++;
      if (ev[i]) m_pend[k][i] = 1'b1;
      else if (ack[i]) m_pend[k][i] = 1'b0;
    end
    for (int j = 4; j > 0; j--) m_smp[k][j] = m_smp[k][j-1];
    m_smp[k][0] = upd & msk;
    if (m_ns[k] < 5) m_ns[k]++;
  endtask

  task automatic compare();
    logic [127:0] ea;
    logic [31:0]  eb;
    ea = '0;
    eb = '0;
    for (int i = 0; i < 16; i++) ea[i*8 +: 8] = m_cnt[0][i][7:0];
    for (int i = 0; i < 4; i++)  eb[i*8 +: 8] = m_cnt[1][i][7:0];
    chk("a_pending", 128'(a_sync), 128'(m_pend[0]));
    chk("a_int_req", 128'(a_req),  128'(m_req[0]));
    chk("a_int_id",  128'(a_id),   128'(m_id[0]));
    chk("a_ovf_cnt", a_ovf,        ea);
    chk("b_pending", 128'(b_sync), 128'(m_pend[1][3:0]));
    chk("b_int_req", 128'(b_req),  128'(m_req[1]));
    chk("b_int_id",  128'(b_id),   128'(m_id[1]));
    chk("b_ovf_cnt", 128'(b_ovf),  128'(eb));
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep(0, 3, 1'b1, 16, a_upd, a_ack, a_en, a_clr);
    mstep(1, 2, 1'b0, 4, {12'h0, b_upd}, {12'h0, b_ack}, {12'h0, b_en}, {12'h0, b_clr});
    #1;
    compare();
    a_ack = 16'h0;
    b_ack = 4'h0;
  endtask

  task automatic ncyc(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_a_sync"}, 128'(a_sync), 128'h0);
    chk({nm, "_a_req"},  128'(a_req),  128'h0);
    chk({nm, "_a_id"},   128'(a_id),   128'h0);
    chk({nm, "_a_ovf"},  a_ovf,        128'h0);
    chk({nm, "_b_sync"}, 128'(b_sync), 128'h0);
    chk({nm, "_b_ovf"},  128'(b_ovf),  128'h0);
  endtask

  function automatic logic [15:0] rbits(input int k);
    logic [15:0] v;
    logic [31:0] r;
    v = 16'hFFFF;
    for (int j = 0; j < k; j++) begin
      r = $urandom;
      v = v & r[15:0];
    end
    return v;
  endfunction

  initial begin
    int hit;
    logic [15:0] r;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a_upd = '0; a_ack = '0; a_en = 16'hFFFF; a_clr = '0;
    b_upd = '0; b_ack = '0; b_en = 4'hF;     b_clr = '0;
    mreset(0);
    mreset(1);
    ncyc(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    ncyc(2);

    // single pulse on channel 2: pending after S+1 edges, interrupt one cycle later
    hit = 99;
    a_upd[2] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) a_upd[2] = 1'b0;
      cyc();
      if (hit == 99 && a_sync == 16'h0004) hit = c;
    end
    chk("ch2_latency", 128'(hit), 128'd4);
    chk("ch2_int_req", 128'(a_req), 128'h1);
    chk("ch2_int_id",  128'(a_id),  128'h2);
    a_ack[2] = 1'b1;
    cyc();
    chk("ch2_ack_sync", 128'(a_sync), 128'h0);
    cyc();
    chk("ch2_ack_req", 128'(a_req), 128'h0);

    // simultaneous events on 3 and 1: lowest index wins
    a_upd[3] = 1'b1; a_upd[1] = 1'b1;
    ncyc(2);
    a_upd[3] = 1'b0; a_upd[1] = 1'b0;
    ncyc(6);
    chk("pri_id_1", 128'(a_id), 128'h1);
    a_ack[1] = 1'b1;
    ncyc(2);
    chk("pri_id_3", 128'(a_id), 128'h3);
    a_ack[3] = 1'b1;
    ncyc(2);
    chk("pri_none_req", 128'(a_req), 128'h0);
    chk("pri_none_id",  128'(a_id),  128'h0);

    // 302 rising edges on channel 0 with no ack: saturate, then clear against an event
    a_upd[0] = 1'b0;
    for (int i = 0; i < 604; i++) begin
      a_upd[0] = ~a_upd[0];
      cyc();
    end
    chk("ovf_sat", 128'(a_ovf[7:0]), 128'hFF);
    a_upd[0] = 1'b0;
    a_clr[0] = 1'b1;
    ncyc(2);
    a_clr[0] = 1'b0;
    chk("ovf_clr", 128'(a_ovf[7:0]), 128'h0);
    ncyc(6);
    a_ack[0] = 1'b1;
    cyc();

    // channel 1: event coinciding with ack keeps pending and count
    a_upd[1] = 1'b1;
    ncyc(3);
    a_upd[1] = 1'b0;
    ncyc(5);
    a_upd[1] = 1'b1;
    ncyc(3);
    a_upd[1] = 1'b0;
    a_ack[1] = 1'b1;
    cyc();
    chk("coinc_pend", 128'(a_sync[1]),   128'h1);
    chk("coinc_ovf",  128'(a_ovf[15:8]), 128'h0);
    a_ack[1] = 1'b1;
    cyc();
    a_en[1] = 1'b0;
    a_upd[1] = 1'b1;
    ncyc(3);
    a_upd[1] = 1'b0;
    ncyc(6);
    chk("dis_pend", 128'(a_sync[1]),   128'h0);
    chk("dis_ovf",  128'(a_ovf[15:8]), 128'h0);
    a_en[1] = 1'b1;

    // level mode: one-cycle pulse sets pending, then 5 high cycles count 5 overruns
    b_upd[0] = 1'b1;
    cyc();
    b_upd[0] = 1'b0;
    ncyc(2);
    b_upd[0] = 1'b1;
    ncyc(5);
    b_upd[0] = 1'b0;
    ncyc(5);
    chk("lvl_ovf5", 128'(b_ovf[7:0]), 128'h5);

    // reset mid-burst with sources held high through release
    b_upd[0] = 1'b1;
    a_upd[5] = 1'b1;
    ncyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    mreset(0);
    mreset(1);
    ncyc(3);
    rst_n = 1'b1;
    ncyc(10);
    chk("held_high_no_edge", 128'(a_sync), 128'h0);
    a_upd[5] = 1'b0;
    ncyc(2);
    a_upd[5] = 1'b1;
    ncyc(6);
    chk("rearm_edge", 128'(a_sync[5]), 128'h1);

    // randomized regression against the model
    for (int i = 0; i < 20000; i++) begin
      a_upd = a_upd ^ rbits(3);
      a_ack = ((i / 2500) % 2 == 0) ? rbits(3) : rbits(6);
      a_en  = ~rbits(4);
      a_clr = ($urandom_range(0, 31) == 0) ? rbits(2) : 16'h0;
      r = rbits(2);
      b_upd = ($urandom_range(0, 3) == 0) ? r[3:0] : b_upd;
      r = rbits(3);
      b_ack = r[3:0];
      r = ~rbits(4);
      b_en = r[3:0];
      r = rbits(2);
      b_clr = ($urandom_range(0, 31) == 0) ? r[3:0] : 4'h0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
